// File: rtl/pred_ctrl_defs.sv
// Shared definitions for the predicate context sequencer: bundle layout,
// NOP bundle, scratch entry and FSM state encoding.
package pred_ctrl_defs;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CTX_W  = 47;

  // Pred entry reserved as the write sink for NOP bundles.
  localparam logic [5:0] SCRATCH = 6'd63;

  // Bundle field offsets, LSB first:
  // {wb(1), in_sel(9), put_in(6), put_out(6), pred_sel(6), send(6), out_sel(9), pe2fu(4)}
  localparam int PE2FU_LSB  = 0;
  localparam int PE2FU_W    = 4;
  localparam int OUTSEL_LSB = 4;
  localparam int OUTSEL_W   = 9;
  localparam int SEND_LSB   = 13;
  localparam int SEND_W     = 6;
  localparam int PRED_LSB   = 19;
  localparam int PRED_W     = 6;
  localparam int PUTOUT_LSB = 25;
  localparam int PUTOUT_W   = 6;
  localparam int PUTIN_LSB  = 31;
  localparam int PUTIN_W    = 6;
  localparam int INSEL_LSB  = 37;
  localparam int INSEL_W    = 9;
  localparam int WB_BIT     = 46;

  // NOP only ever writes 0 into SCRATCH.
  localparam logic [CTX_W-1:0] CTX_NOP =
    {1'b0, 9'd0, SCRATCH, SCRATCH, 6'd0, 6'd0, 9'd0, 4'd0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pred_ctx_mem.sv
// Context memory: DEPTH x CTX_W register array, one synchronous write port
// and one asynchronous read port. Deliberately not reset.
module pred_ctx_mem
  import pred_ctrl_defs::*;
(
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CTX_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CTX_W-1:0]  rdata
);

  logic [CTX_W-1:0] mem [DEPTH];

  // Write port; data is visible on the read port from the next cycle.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pred_ctx_sequencer.sv
// Context sequencer for one PE's predicate register file: replays the
// context memory for a programmed number of loop iterations and drives the
// file's control bundle from a register updated on the rising edge.
//
// state | meaning
// IDLE  | outputs NOP, context memory writable, waiting for start
// RUN   | issuing bundles mem[pc]; stall inserts NOP and holds pc/iter
// DONE  | outputs NOP, done pulse for one cycle, then back to IDLE
module pred_ctx_sequencer
  import pred_ctrl_defs::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CTX_W-1:0]  cfg_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_ctx,
  input  logic [15:0]       iter_count,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       iter,
  output logic              write_back_p,
  output logic [8:0]        control_in_p,
  output logic [5:0]        control_put_in_p,
  output logic [5:0]        control_put_out_p,
  output logic [5:0]        control_pred,
  output logic [5:0]        control_send_p,
  output logic [8:0]        control_out_p,
  output logic [3:0]        control_pe2fu_p
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [15:0]       iter_q, iter_d;
  logic [15:0]       n_q, n_d;
  logic [CTX_W-1:0]  bundle_q, bundle_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_raddr;
  logic [CTX_W-1:0]  mem_rdata;

  // Configuration writes are only accepted while the sequence is idle.
  assign mem_we = cfg_we && (state_q == IDLE);

  pred_ctx_mem u_mem (
    .CLK   (CLK),
    .we    (mem_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Next state, counters and next bundle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    iter_d   = iter_q;
    last_d   = last_q;
    n_d      = n_q;
    bundle_d = CTX_NOP;
    // Read address is the index of the bundle to be issued at the next edge.
    if (state_q == RUN && pc_q != last_q) mem_raddr = pc_q + ADDR_W'(1);
    else                                  mem_raddr = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          iter_d  = '0;
          last_d  = last_ctx;
          n_d     = (iter_count == 16'd0) ? 16'd1 : iter_count;
          // A same-cycle write to entry 0 has not landed yet; forward it.
          bundle_d = (cfg_we && cfg_addr == '0) ? cfg_data : mem_rdata;
        end
      end
      RUN: begin
        if (!stall) begin
          if (pc_q == last_q) begin
            if (iter_q == n_q - 16'd1) begin
              state_d = DONE;
            end else begin
              pc_d     = '0;
              iter_d   = iter_q + 16'd1;
              bundle_d = mem_rdata;
            end
          end else begin
            pc_d     = pc_q + ADDR_W'(1);
            bundle_d = mem_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counters, latched loop parameters and the output bundle register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q     <= '0;
      iter_q   <= '0;
      last_q   <= '0;
      n_q      <= 16'd1;
      bundle_q <= CTX_NOP;
    end else begin
      pc_q     <= pc_d;
      iter_q   <= iter_d;
      last_q   <= last_d;
      n_q      <= n_d;
      bundle_q <= bundle_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign pc   = pc_q;
  assign iter = iter_q;

  assign write_back_p      = bundle_q[WB_BIT];
  assign control_in_p      = bundle_q[INSEL_LSB  +: INSEL_W];
  assign control_put_in_p  = bundle_q[PUTIN_LSB  +: PUTIN_W];
  assign control_put_out_p = bundle_q[PUTOUT_LSB +: PUTOUT_W];
  assign control_pred      = bundle_q[PRED_LSB   +: PRED_W];
  assign control_send_p    = bundle_q[SEND_LSB   +: SEND_W];
  assign control_out_p     = bundle_q[OUTSEL_LSB +: OUTSEL_W];
  assign control_pe2fu_p   = bundle_q[PE2FU_LSB  +: PE2FU_W];

endmodule

// File: tb/tb_pred_ctx_sequencer.sv
// Directed testbench for pred_ctx_sequencer.
module tb_pred_ctx_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [46:0] cfg_data;
  logic        start;
  logic [3:0]  last_ctx;
  logic [15:0] iter_count;
  logic        stall;
  logic        busy;
  logic        done;
  logic [3:0]  pc;
  logic [15:0] iter;
  logic        write_back_p;
  logic [8:0]  control_in_p;
  logic [5:0]  control_put_in_p;
  logic [5:0]  control_put_out_p;
  logic [5:0]  control_pred;
  logic [5:0]  control_send_p;
  logic [8:0]  control_out_p;
  logic [3:0]  control_pe2fu_p;

  logic [46:0] obs;
  logic [46:0] ctx_m [16];
  logic [46:0] nop_b;
  int          n_chk;
  int          n_fail;

  pred_ctx_sequencer dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .cfg_we            (cfg_we),
    .cfg_addr          (cfg_addr),
    .cfg_data          (cfg_data),
    .start             (start),
    .last_ctx          (last_ctx),
    .iter_count        (iter_count),
    .stall             (stall),
    .busy              (busy),
    .done              (done),
    .pc                (pc),
    .iter              (iter),
    .write_back_p      (write_back_p),
    .control_in_p      (control_in_p),
    .control_put_in_p  (control_put_in_p),
    .control_put_out_p (control_put_out_p),
    .control_pred      (control_pred),
    .control_send_p    (control_send_p),
    .control_out_p     (control_out_p),
    .control_pe2fu_p   (control_pe2fu_p)
  );

  assign obs = {write_back_p, control_in_p, control_put_in_p, control_put_out_p,
                control_pred, control_send_p, control_out_p, control_pe2fu_p};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [46:0] mk(input int i);
    logic [8:0] insel;
    insel = 9'(1 << (2 + (i % 3)));
    return {1'b1, insel, 6'(i), 6'(i + 20), 6'(i + 1), 6'(i + 40), 9'(i * 7 + 3), 4'(i)};
  endfunction

  task automatic load(input int a, input logic [46:0] d);
    cfg_we   = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic start_seq(input int last, input int n);
    last_ctx   = 4'(last);
    iter_count = 16'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    for (int k = 0; k < max_cyc && !done; k++) tick();
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    nop_b      = {1'b0, 9'd0, 6'd63, 6'd63, 6'd0, 6'd0, 9'd0, 4'd0};
    RST_N      = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    start      = 1'b0;
    last_ctx   = '0;
    iter_count = '0;
    stall      = 1'b0;
    #17;
    chk("rst_bundle", 64'(obs), 64'(nop_b));
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_pc",     64'(pc),   64'd0);
    chk("rst_iter",   64'(iter), 64'd0);
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      ctx_m[i] = mk(i);
      load(i, ctx_m[i]);
    end
    chk("idle_nop", 64'(obs), 64'(nop_b));

    // Three contexts, three iterations.
    start_seq(2, 3);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("loop_b%0d", k),    64'(obs),  64'(ctx_m[k % 3]));
      chk($sformatf("loop_pc%0d", k),   64'(pc),   64'(k % 3));
      chk($sformatf("loop_iter%0d", k), 64'(iter), 64'(k / 3));
      chk($sformatf("loop_done%0d", k), 64'(done), 64'd0);
      tick();
    end
    chk("loop_done",      64'(done), 64'd1);
    chk("loop_done_busy", 64'(busy), 64'd1);
    chk("loop_done_nop",  64'(obs),  64'(nop_b));
    tick();
    chk("loop_idle_busy", 64'(busy), 64'd0);
    chk("loop_idle_done", 64'(done), 64'd0);

    // Stall for two cycles while bundle 0 is on the outputs.
    start_seq(2, 1);
    chk("stall_b0", 64'(obs), 64'(ctx_m[0]));
    stall = 1'b1;
    tick();
    chk("stall_nop1",    64'(obs),              64'(nop_b));
    chk("stall_putin1",  64'(control_put_in_p), 64'd63);
    chk("stall_wb1",     64'(write_back_p),     64'd0);
    chk("stall_pc1",     64'(pc),               64'd0);
    tick();
    chk("stall_nop2",    64'(obs),              64'(nop_b));
    chk("stall_pc2",     64'(pc),               64'd0);
    stall = 1'b0;
    tick();
    chk("stall_b1",      64'(obs), 64'(ctx_m[1]));
    chk("stall_b1_pc",   64'(pc),  64'd1);
    tick();
    chk("stall_b2",      64'(obs), 64'(ctx_m[2]));
    chk("stall_b2_done", 64'(done), 64'd0);
    tick();
    chk("stall_done",    64'(done), 64'd1);
    tick();

    // Zero iterations, single context.
    start_seq(0, 0);
    chk("zero_b0",   64'(obs),  64'(ctx_m[0]));
    chk("zero_busy", 64'(busy), 64'd1);
    chk("zero_nd",   64'(done), 64'd0);
    tick();
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_nop",  64'(obs),  64'(nop_b));
    tick();
    chk("zero_idle", 64'(busy), 64'd0);

    // Config write and restart while busy are ignored.
    start_seq(1, 2);
    chk("busy_b0", 64'(obs), 64'(ctx_m[0]));
    cfg_we     = 1'b1;
    cfg_addr   = 4'd1;
    cfg_data   = mk(99);
    start      = 1'b1;
    last_ctx   = 4'd0;
    iter_count = 16'd0;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
    chk("busy_b1",      64'(obs),  64'(ctx_m[1]));
    tick();
    chk("busy_b0_it1",  64'(obs),  64'(ctx_m[0]));
    chk("busy_iter1",   64'(iter), 64'd1);
    tick();
    chk("busy_b1_it1",  64'(obs),  64'(ctx_m[1]));
    chk("busy_nd",      64'(done), 64'd0);
    tick();
    chk("busy_done",    64'(done), 64'd1);
    tick();
    start_seq(1, 1);
    tick();
    chk("mem1_kept",    64'(obs),  64'(ctx_m[1]));
    tick();
    chk("mem1_done",    64'(done), 64'd1);
    tick();

    // Write to entry 0 together with start.
    ctx_m[0]   = mk(77);
    cfg_we     = 1'b1;
    cfg_addr   = 4'd0;
    cfg_data   = ctx_m[0];
    start_seq(0, 1);
    cfg_we     = 1'b0;
    chk("bypass_b0",   64'(obs),  64'(ctx_m[0]));
    tick();
    chk("bypass_done", 64'(done), 64'd1);
    tick();

    // Asynchronous reset in the middle of a run.
    start_seq(7, 1);
    repeat (5) tick();
    chk("mid_pc5", 64'(pc),  64'd5);
    chk("mid_b5",  64'(obs), 64'(ctx_m[5]));
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_nop",  64'(obs),  64'(nop_b));
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_pc",   64'(pc),   64'd0);
    #2;
    RST_N = 1'b1;
    tick();
    chk("arst_idle", 64'(obs), 64'(nop_b));
    start_seq(3, 1);
    chk("arst_b0", 64'(obs), 64'(ctx_m[0]));
    chk("arst_pc0", 64'(pc), 64'd0);
    wait_done("arst_run_done", 20);
    tick();
    chk("arst_end_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
